// File: rtl/drm_pkg.sv
// drm_pkg -- shared types and sizes for the DRM code loader.
//   CODE_W      width of the committed activation code
//   WORD_W      width of one host code word
//   WORDS       host words per code
//   WORD_IDX_W  width of the word index inside a code
//   drm_state_e loader FSM states
package drm_pkg;

    localparam int CODE_W     = 128;
    localparam int WORD_W     = 32;
    localparam int WORDS      = 4;
    localparam int WORD_IDX_W = $clog2(WORDS);

    typedef enum logic [1:0] {
        ST_LOAD     = 2'd0,
        ST_CHECK    = 2'd1,
        ST_UNLOCKED = 2'd2,
        ST_LOCKOUT  = 2'd3
    } drm_state_e;

endpackage

// File: rtl/drm_lockout_timer.sv
// drm_lockout_timer -- one-shot lockout interval timer.
// A start pulse loads a down-counter with CYCLES-1; done pulses for one
// cycle when the count reaches zero, i.e. CYCLES cycles after start.
// Ports:
//   clk_in    clock, rising edge
//   rst_n_in  asynchronous active-low reset
//   start     pulse, (re)starts the interval
//   done      one-cycle pulse on the last cycle of the interval
module drm_lockout_timer #(
    parameter int unsigned CYCLES = 1024
) (
    input  logic clk_in,
    input  logic rst_n_in,
    input  logic start,
    output logic done
);

    localparam int unsigned CNT_W = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    logic [CNT_W-1:0] cnt;
    logic             running;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt     <= '0;
            running <= 1'b0;
        end else if (start) begin
            cnt     <= CNT_W'(CYCLES - 1);
            running <= 1'b1;
        end else if (running) begin
            if (cnt == '0) begin
                running <= 1'b0;
            end else begin
                cnt <= cnt - CNT_W'(1);
            end
        end
    end

    assign done = running && (cnt == '0);

endmodule

// File: rtl/drm_code_loader.sv
// drm_code_loader -- loads a 128-bit activation code as four 32-bit host
// words, commits it atomically to the activation checker and tracks the
// checker's verdict.
// Optional feature macro: DRM_LOADER_LOCKOUT_EN -- when defined, reaching
// MAX_TRIES failed checks locks the loader out for LOCKOUT_CYCLES cycles.
// Ports:
//   clk_in           clock, rising edge
//   rst_n_in         asynchronous active-low reset
//   wr_valid/wr_data host code word, first word is the MSB word
//   wr_ready         loader accepts a word this cycle
//   clear            discard the partially loaded code (LOAD only)
//   activation_code  committed code, never partial
//   enable_in        checker match result
//   RDY_enable_in    checker result valid
//   unlocked         sticky, code accepted
//   locked_out       lockout in progress
//   fail_cnt         failed checks since last lockout or reset
//
// state    | meaning
// LOAD     | collecting host words into the staging register
// CHECK    | code committed, waiting for the checker verdict
// UNLOCKED | code accepted, everything frozen until reset
// LOCKOUT  | too many failures, waiting out the lockout timer
module drm_code_loader
    import drm_pkg::*;
#(
    parameter int unsigned MAX_TRIES      = 3,
    parameter int unsigned LOCKOUT_CYCLES = 1024
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              wr_valid,
    input  logic [WORD_W-1:0] wr_data,
    output logic              wr_ready,
    input  logic              clear,
    output logic [CODE_W-1:0] activation_code,
    input  logic              enable_in,
    input  logic              RDY_enable_in,
    output logic              unlocked,
    output logic              locked_out,
    output logic [3:0]        fail_cnt
);

    if (MAX_TRIES < 1 || MAX_TRIES > 15 || LOCKOUT_CYCLES < 1 || LOCKOUT_CYCLES > (1 << 20)) begin : g_bad_params
        $error("drm_code_loader: MAX_TRIES or LOCKOUT_CYCLES out of range");
    end

    drm_state_e            state;
    logic [CODE_W-1:0]     staging;
    logic [WORD_IDX_W-1:0] word_idx;
    logic [3:0]            fail_inc;
    logic                  chk_fail;
    logic                  lock_start;

    assign wr_ready = (state == ST_LOAD);
    assign chk_fail = (state == ST_CHECK) && RDY_enable_in && !enable_in;
    assign fail_inc = (fail_cnt == 4'hF) ? fail_cnt : fail_cnt + 4'd1;

`ifdef DRM_LOADER_LOCKOUT_EN
    logic lock_done;

    assign lock_start = chk_fail && (fail_inc == 4'(MAX_TRIES));
    assign locked_out = (state == ST_LOCKOUT);

    drm_lockout_timer #(
        .CYCLES (LOCKOUT_CYCLES)
    ) u_lockout_timer (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .start    (lock_start),
        .done     (lock_done)
    );
`else
    assign lock_start = 1'b0;
    assign locked_out = 1'b0;
`endif

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state           <= ST_LOAD;
            staging         <= '0;
            word_idx        <= '0;
            activation_code <= '0;
            fail_cnt        <= '0;
            unlocked        <= 1'b0;
        end else begin
            case (state)
                ST_LOAD: begin
                    // clear has priority: a word presented with clear is dropped
                    if (clear) begin
                        staging  <= '0;
                        word_idx <= '0;
                    end else if (wr_valid) begin
                        // shift in MSB-first: after four words the first sits in [127:96]
                        staging <= {staging[CODE_W-WORD_W-1:0], wr_data};
                        if (word_idx == WORD_IDX_W'(WORDS - 1)) begin
                            activation_code <= {staging[CODE_W-WORD_W-1:0], wr_data};
                            word_idx        <= '0;
                            state           <= ST_CHECK;
                        end else begin
                            word_idx <= word_idx + WORD_IDX_W'(1);
                        end
                    end
                end
                ST_CHECK: begin
                    if (RDY_enable_in) begin
                        if (enable_in) begin
                            unlocked <= 1'b1;
                            state    <= ST_UNLOCKED;
                        end else begin
                            fail_cnt        <= fail_inc;
                            activation_code <= '0;
                            staging         <= '0;
                            word_idx        <= '0;
                            state           <= lock_start ? ST_LOCKOUT : ST_LOAD;
                        end
                    end
                end
                ST_UNLOCKED: begin
                    state <= ST_UNLOCKED;
                end
`ifdef DRM_LOADER_LOCKOUT_EN
                ST_LOCKOUT: begin
                    if (lock_done) begin
                        fail_cnt <= '0;
                        state    <= ST_LOAD;
                    end
                end
`endif
                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_drm_code_loader.sv
// tb_drm_code_loader -- self-checking bench for drm_code_loader.
// A queue-based model of the loader rules is compared against the DUT on
// every falling clock edge; directed sequences add literal expectations.
module tb_drm_code_loader;

    localparam logic [127:0] GOLD      = 128'h87C0D0FD94C369FA1A4B7E7BC00BD074;
    localparam logic [31:0]  G0        = 32'h87C0D0FD;
    localparam logic [31:0]  G1        = 32'h94C369FA;
    localparam logic [31:0]  G2        = 32'h1A4B7E7B;
    localparam logic [31:0]  G3        = 32'hC00BD074;
    localparam int           MAX_TRIES = 3;
    localparam int           LOCK_LEN  = 1024;

    logic         clk_in    = 1'b0;
    logic         rst_n_in  = 1'b0;
    logic         wr_valid  = 1'b0;
    logic [31:0]  wr_data   = '0;
    logic         clear     = 1'b0;
    logic         rdy       = 1'b0;
    logic         wr_ready;
    logic         enable_in;
    logic         unlocked;
    logic         locked_out;
    logic [3:0]   fail_cnt;
    logic [127:0] activation_code;

    int checks   = 0;
    int failures = 0;
    bit cmp_on   = 1'b0;

    always #5 clk_in = ~clk_in;

    // activation checker stand-in: matches only the golden code
    assign enable_in = (activation_code == GOLD);

    drm_code_loader #(
        .MAX_TRIES      (MAX_TRIES),
        .LOCKOUT_CYCLES (LOCK_LEN)
    ) dut (
        .clk_in          (clk_in),
        .rst_n_in        (rst_n_in),
        .wr_valid        (wr_valid),
        .wr_data         (wr_data),
        .wr_ready        (wr_ready),
        .clear           (clear),
        .activation_code (activation_code),
        .enable_in       (enable_in),
        .RDY_enable_in   (rdy),
        .unlocked        (unlocked),
        .locked_out      (locked_out),
        .fail_cnt        (fail_cnt)
    );

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [31:0]  m_words[$];
    logic [127:0] m_code      = '0;
    bit           m_pending   = 1'b0;
    bit           m_unlocked  = 1'b0;
    int           m_fail      = 0;
    int           m_lock_left = 0;

    always @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            m_words.delete();
            m_code      = '0;
            m_pending   = 1'b0;
            m_unlocked  = 1'b0;
            m_fail      = 0;
            m_lock_left = 0;
        end else if (m_lock_left > 0) begin
            m_lock_left--;
            if (m_lock_left == 0) m_fail = 0;
        end else if (m_unlocked) begin
            m_unlocked = 1'b1;
        end else if (m_pending) begin
            if (rdy) begin
                m_pending = 1'b0;
                if (m_code == GOLD) begin
                    m_unlocked = 1'b1;
                end else begin
                    m_fail = (m_fail < 15) ? m_fail + 1 : 15;
                    m_code = '0;
`ifdef DRM_LOADER_LOCKOUT_EN
                    if (m_fail == MAX_TRIES) m_lock_left = LOCK_LEN;
`endif
                end
            end
        end else if (clear) begin
            m_words.delete();
        end else if (wr_valid) begin
            m_words.push_back(wr_data);
            if (m_words.size() == 4) begin
                m_code = {m_words[0], m_words[1], m_words[2], m_words[3]};
                m_words.delete();
                m_pending = 1'b1;
            end
        end
    end

    always @(negedge clk_in) begin
        if (cmp_on && rst_n_in) begin
            chk("m_code", activation_code, m_code);
            chk("m_ready", {127'd0, wr_ready}, {127'd0, !m_unlocked && !m_pending && m_lock_left == 0});
            chk("m_unlocked", {127'd0, unlocked}, {127'd0, m_unlocked});
            chk("m_locked_out", {127'd0, locked_out}, {127'd0, m_lock_left > 0});
            chk("m_fail_cnt", {124'd0, fail_cnt}, 128'(m_fail));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk_in);
        #1;
    endtask

    task automatic write_word(input logic [31:0] d);
        wr_valid = 1'b1;
        wr_data  = d;
        step();
        wr_valid = 1'b0;
    endtask

    task automatic write_code(input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] c, input logic [31:0] d);
        write_word(a);
        write_word(b);
        write_word(c);
        write_word(d);
    endtask

    task automatic check_result();
        rdy = 1'b1;
        step();
        rdy = 1'b0;
    endtask

    task automatic fail_once();
        write_code(G0, G1, G2, 32'h0);
        check_result();
    endtask

    task automatic async_reset(input string tag);
        @(posedge clk_in);
        #2;
        rst_n_in = 1'b0;
        #1;
        chk({tag, "_code"}, activation_code, 128'd0);
        chk({tag, "_unlocked"}, {127'd0, unlocked}, 128'd0);
        chk({tag, "_locked_out"}, {127'd0, locked_out}, 128'd0);
        chk({tag, "_fail_cnt"}, {124'd0, fail_cnt}, 128'd0);
        @(posedge clk_in);
        #1;
        rst_n_in = 1'b1;
        chk({tag, "_ready"}, {127'd0, wr_ready}, 128'd1);
    endtask

    initial begin
        #400000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        int lock_len;

        step();
        step();
        chk("rst_code", activation_code, 128'd0);
        chk("rst_unlocked", {127'd0, unlocked}, 128'd0);
        chk("rst_fail_cnt", {124'd0, fail_cnt}, 128'd0);
        rst_n_in = 1'b1;
        cmp_on   = 1'b1;
        chk("rst_ready", {127'd0, wr_ready}, 128'd1);

        // wrong code
        fail_once();
        chk("wrong_fail_cnt", {124'd0, fail_cnt}, 128'd1);
        chk("wrong_code", activation_code, 128'd0);
        chk("wrong_ready", {127'd0, wr_ready}, 128'd1);

        fail_once();
        fail_once();
`ifdef DRM_LOADER_LOCKOUT_EN
        chk("lock_active", {127'd0, locked_out}, 128'd1);
        chk("lock_ready", {127'd0, wr_ready}, 128'd0);
        chk("lock_fail_cnt", {124'd0, fail_cnt}, 128'd3);
        lock_len = 0;
        wr_valid = 1'b1;
        wr_data  = G0;
        while (locked_out && lock_len < 2000) begin
            lock_len++;
            step();
        end
        wr_valid = 1'b0;
        chk("lock_len", 128'(lock_len), 128'(LOCK_LEN));
        chk("lock_exit_fail_cnt", {124'd0, fail_cnt}, 128'd0);
        chk("lock_exit_ready", {127'd0, wr_ready}, 128'd1);
`else
        lock_len = 0;
        chk("nolock_locked_out", {127'd0, locked_out}, 128'd0);
        chk("nolock_fail_cnt", {124'd0, fail_cnt}, 128'd3);
        chk("nolock_ready", {127'd0, wr_ready}, 128'd1);
        repeat (13) fail_once();
        chk("fail_sat", {124'd0, fail_cnt}, 128'd15);
`endif

        // two words, clear with a simultaneous word, then the full code
        write_word(G0);
        write_word(G1);
        clear    = 1'b1;
        wr_valid = 1'b1;
        wr_data  = G2;
        step();
        clear    = 1'b0;
        wr_valid = 1'b0;
        chk("clear_code", activation_code, 128'd0);
        write_code(G0, G1, G2, G3);
        chk("commit_code", activation_code, GOLD);
        chk("commit_ready", {127'd0, wr_ready}, 128'd0);

        // checker not ready for five cycles
        for (int i = 0; i < 5; i++) begin
            step();
            chk("wait_code", activation_code, GOLD);
            chk("wait_unlocked", {127'd0, unlocked}, 128'd0);
            chk("wait_ready", {127'd0, wr_ready}, 128'd0);
        end
        check_result();
        chk("unlock", {127'd0, unlocked}, 128'd1);
        chk("unlock_ready", {127'd0, wr_ready}, 128'd0);

        // writes and clear ignored once unlocked
        write_word(32'hDEADBEEF);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("hold_code", activation_code, GOLD);
        chk("hold_unlocked", {127'd0, unlocked}, 128'd1);

        async_reset("rst_unlocked");

        // reset mid-load: the next load starts at word 0
        write_word(G0);
        write_word(G1);
        async_reset("rst_midload");
        write_code(G0, G1, G2, G3);
        chk("reload_code", activation_code, GOLD);
        check_result();
        chk("reload_unlock", {127'd0, unlocked}, 128'd1);

        // reset mid-check
        async_reset("rst_pre_check");
        write_code(G0, G1, G2, G3);
        async_reset("rst_midcheck");

`ifdef DRM_LOADER_LOCKOUT_EN
        fail_once();
        fail_once();
        fail_once();
        repeat (100) step();
        chk("midlock_active", {127'd0, locked_out}, 128'd1);
        async_reset("rst_midlock");
`endif

        write_code(G0, G1, G2, G3);
        check_result();
        chk("final_unlock", {127'd0, unlocked}, 128'd1);

        step();
        cmp_on = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
